// File: rtl/core85_pkg.sv
// Shared definitions for the 8085 core: ienb and instruction-info bit
// positions, T-state encodings and bus status codes.
package core85_pkg;

    // ienb bit positions
    localparam int IENB_RRD = 0;
    localparam int IENB_RWR = 1;
    localparam int IENB_COD = 2;
    localparam int IENB_DAT = 3;
    localparam int IENB_PC  = 4;
    localparam int IENB_PD  = 5;

    // decoded instruction info bit positions
    localparam int INST_GO6   = 0;
    localparam int INST_DAD   = 1;
    localparam int INST_HLT   = 2;
    localparam int INST_DIO   = 3;
    localparam int INST_CY_LO = 4;
    localparam int INST_RW_LO = 8;
    localparam int INST_CD_LO = 12;
    localparam int INST_CCC   = 16;

    // T-state encodings; TH uses 0 so that every T-state keeps its own code
    localparam logic [2:0] ST_TH = 3'd0;
    localparam logic [2:0] ST_T1 = 3'd1;
    localparam logic [2:0] ST_T2 = 3'd2;
    localparam logic [2:0] ST_T3 = 3'd3;
    localparam logic [2:0] ST_T4 = 3'd4;
    localparam logic [2:0] ST_T5 = 3'd5;
    localparam logic [2:0] ST_T6 = 3'd6;
    localparam logic [2:0] ST_TW = 3'd7;

    // bus status {s1,s0}
    localparam logic [1:0] STAT_FETCH = 2'b11;
    localparam logic [1:0] STAT_READ  = 2'b10;
    localparam logic [1:0] STAT_WRITE = 2'b01;
    localparam logic [1:0] STAT_IDLE  = 2'b00;

endpackage

// File: rtl/cyc_next.sv
// Picks the machine cycle that follows cycle n: the lowest set CY bit whose
// cycle number is above n. When none remains the instruction is done and the
// next cycle is a fresh M1.
module cyc_next
    import core85_pkg::*;
#(
    parameter int INFO_CYC = 4
) (
    input  logic [INFO_CYC-1:0] cy,
    input  logic [2:0]          n,
    output logic [2:0]          next_n,
    output logic                last
);

    // scan from the top down so the lowest qualifying bit wins
    always_comb begin
        next_n = 3'd1;
        last   = 1'b1;
        for (int k = INFO_CYC - 1; k >= 0; k--) begin
            if (cy[k] && ((k + 2) > int'(n))) begin
                next_n = 3'(k + 2);
                last   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cycle_ctrl.sv
// Machine-cycle / T-state sequencer for the 8085 core. Runs the M1 opcode
// fetch, then the extra M2..M5 cycles flagged in the decoded instruction info,
// inserting READY wait states and parking in TH on HLT. Drives the alureg
// enables and the external bus strobes, all decoded from state.
module cycle_ctrl
    import core85_pkg::*;
#(
    parameter int IENBSIZE = 6,
    parameter int INSTSIZE = 17,
    parameter int INFO_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [INSTSIZE-1:0] chk_i,
    input  logic                ready,
    output logic [IENBSIZE-1:0] ienb,
    output logic                rd_,
    output logic                wr_,
    output logic                ale,
    output logic                iom,
    output logic                s1,
    output logic                s0,
    output logic                hlta,
    output logic [2:0]          mcyc,
    output logic [2:0]          tst
);

    logic [2:0]          state, state_nx;
    logic [2:0]          mcyc_q, mcyc_nx;
    logic [15:0]         info;
    logic [INFO_CYC-1:0] chk_cy, info_cy, info_rw, info_cd, cy_sel;
    logic [1:0]          mi;
    logic [2:0]          nx_n;
    logic                nx_last;
    logic                internal, cur_rw, cur_cd;
    logic [1:0]          stat;
    logic                unused_bits;

    assign chk_cy  = chk_i[INST_CY_LO +: INFO_CYC];
    assign info_cy = info[INST_CY_LO +: INFO_CYC];
    assign info_rw = info[INST_RW_LO +: INFO_CYC];
    assign info_cd = info[INST_CD_LO +: INFO_CYC];

    // CCC belongs to alureg; GO6 is only needed live in T4
    assign unused_bits = chk_i[INST_CCC] ^ info[INST_GO6];

    // info is latched only at the end of T4, so T4 itself must see chk_i live
    assign cy_sel = (state == ST_T4) ? chk_cy : info_cy;

    cyc_next #(.INFO_CYC(INFO_CYC)) u_cyc_next (
        .cy     (cy_sel),
        .n      (mcyc_q),
        .next_n (nx_n),
        .last   (nx_last)
    );

    // per-cycle attributes of the current Mn (meaningless in M1, gated there)
    assign mi       = 2'(mcyc_q - 3'd2);
    assign cur_rw   = info_rw[mi];
    assign cur_cd   = info_cd[mi];
    assign internal = info[INST_DAD] && ((mcyc_q == 3'd2) || (mcyc_q == 3'd3));

    // next T-state and machine cycle
    always_comb begin
        state_nx = state;
        mcyc_nx  = mcyc_q;
        case (state)
            ST_T1: state_nx = ST_T2;
            ST_T2: state_nx = (!internal && !ready) ? ST_TW : ST_T3;
            ST_TW: if (ready) state_nx = ST_T3;
            ST_T3: begin
                if (mcyc_q == 3'd1) begin
                    state_nx = ST_T4;
                end else begin
                    state_nx = ST_T1;
                    mcyc_nx  = nx_n;
                end
            end
            ST_T4: begin
                if (chk_i[INST_GO6]) begin
                    state_nx = ST_T5;
                end else if (chk_i[INST_HLT]) begin
                    state_nx = ST_TH;
                    mcyc_nx  = 3'd1;
                end else begin
                    state_nx = ST_T1;
                    mcyc_nx  = nx_n;
                end
            end
            ST_T5: state_nx = ST_T6;
            ST_T6: begin
                if (info[INST_HLT]) begin
                    state_nx = ST_TH;
                    mcyc_nx  = 3'd1;
                end else begin
                    state_nx = ST_T1;
                    mcyc_nx  = nx_n;
                end
            end
            ST_TH: state_nx = ST_TH;
            default: begin
                state_nx = ST_T1;
                mcyc_nx  = 3'd1;
            end
        endcase
    end

    // sequencer state; reset may land mid-cycle and restarts the fetch
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state  <= ST_T1;
            mcyc_q <= 3'd1;
        end else begin
            state  <= state_nx;
            mcyc_q <= mcyc_nx;
        end
    end

    // capture instruction info at the end of M1 T4; it steers the rest of the instruction
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            info <= '0;
        end else if (state == ST_T4) begin
            info <= chk_i[15:0];
        end
    end

    // bus strobes, status and alureg enables decoded from state
    always_comb begin
        ienb = '0;
        ale  = 1'b0;
        rd_  = 1'b1;
        wr_  = 1'b1;
        hlta = 1'b0;
        stat = STAT_IDLE;
        if (state == ST_TH) begin
            hlta = 1'b1;
        end else if (mcyc_q == 3'd1) begin
            stat = STAT_FETCH;
            ale  = (state == ST_T1);
            rd_  = !((state == ST_T2) || (state == ST_TW) || (state == ST_T3));
            if (state == ST_T2) ienb[IENB_PC]  = 1'b1;
            if (state == ST_T3) ienb[IENB_COD] = 1'b1;
            if (((state == ST_T4) && !chk_i[INST_GO6] && (chk_cy == '0)) ||
                ((state == ST_T6) && (info_cy == '0))) begin
                ienb[IENB_RRD] = 1'b1;
                ienb[IENB_RWR] = 1'b1;
            end
        end else if (internal) begin
            if (cur_cd) ienb[IENB_PD] = 1'b1;
            if ((state == ST_T3) && nx_last && !cur_rw) ienb[IENB_RWR] = 1'b1;
        end else begin
            ale = (state == ST_T1);
            if (cur_cd) ienb[IENB_PD] = 1'b1;
            if (cur_rw) begin
                stat           = STAT_WRITE;
                wr_            = !((state == ST_T2) || (state == ST_TW) || (state == ST_T3));
                ienb[IENB_RRD] = 1'b1;
            end else begin
                stat = STAT_READ;
                rd_  = !((state == ST_T2) || (state == ST_TW) || (state == ST_T3));
                if ((state == ST_T2) && !cur_cd) ienb[IENB_PC]  = 1'b1;
                if (state == ST_T3)              ienb[IENB_DAT] = 1'b1;
                if ((state == ST_T3) && nx_last) ienb[IENB_RWR] = 1'b1;
            end
        end
    end

    assign iom  = (state != ST_TH) && (mcyc_q == 3'd3) && info[INST_DIO];
    assign s1   = stat[1];
    assign s0   = stat[0];
    assign mcyc = mcyc_q;
    assign tst  = (state == ST_TH) ? 3'd7 : state;

endmodule
